// File: rtl/fp_pkg.sv
// Shared floating-point constants and FSM state type, common to the FMA datapath
// and its normalise/round back end.
package fp_pkg;

  localparam int FP_BIAS      = 127;
  localparam int FP_EXP_W     = 8;
  localparam int FP_FRAC_W    = 23;
  localparam int FP_EXP_IN_W  = 10;
  localparam int FP_MANT_W    = 27;
  localparam int FP_EXP_INT_W = 12;

  localparam logic [FP_EXP_W-1:0]  FP_EXP_MAX = 8'hFF;
  localparam logic [FP_EXP_W-1:0]  FP_EXP_ZERO = 8'h00;
  localparam logic [FP_FRAC_W-1:0] FP_FRAC_ZERO = 23'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    PACK  = 2'd3
  } fp_state_e;

  // Assemble an IEEE 754 single from its three fields.
  function automatic logic [31:0] fp_pack(input logic s,
                                          input logic [FP_EXP_W-1:0] e,
                                          input logic [FP_FRAC_W-1:0] f);
    return {s, e, f};
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment and inexact detection on the 27-bit
// working mantissa {carry, hidden, fraction[22:0], guard, round}.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [FP_MANT_W-1:0] mant_i,
  input  logic                 sticky_i,
  output logic [FP_MANT_W-3:0] mant_o,
  output logic                 inexact_o
);

  logic inc_s;

  // Increment on guard set unless exactly halfway with an even lsb.
  always_comb begin
    inc_s     = mant_i[1] & (mant_i[0] | sticky_i | mant_i[2]);
    inexact_o = mant_i[1] | mant_i[0] | sticky_i;
    mant_o    = mant_i[FP_MANT_W-1:2] + {{(FP_MANT_W-3){1'b0}}, inc_s};
  end

endmodule

// File: rtl/fp_norm_round.sv
// Sequential normalise / round-to-nearest-even / pack back end for single precision.
// Optional gradual underflow is enabled with `define FP_NORM_SUBNORMAL_EN.
module fp_norm_round
  import fp_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sign_in,
  input  logic [FP_EXP_IN_W-1:0] exp_in,
  input  logic [FP_MANT_W-1:0]   mant_in,
  input  logic                   sticky_in,
  output logic [31:0]            result,
  output logic                   done,
  output logic                   busy,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   inexact
);

  fp_state_e                       state_q, state_d;
  logic                            sign_q, sign_d;
  logic signed [FP_EXP_INT_W-1:0]  exp_q, exp_d;
  logic [FP_MANT_W-1:0]            mant_q, mant_d;
  logic                            sticky_q, sticky_d;
  logic                            flush_q, flush_d;
  logic [31:0]                     result_q, result_d;
  logic                            done_q, done_d;
  logic                            busy_q, busy_d;
  logic                            overflow_q, overflow_d;
  logic                            underflow_q, underflow_d;
  logic                            inexact_q, inexact_d;
`ifdef FP_NORM_SUBNORMAL_EN
  logic [4:0]                      dcnt_q, dcnt_d;
`endif

  logic [FP_MANT_W-3:0]            rnd_mant_s;
  logic                            rnd_inexact_s;

  fp_round_rne u_round (
    .mant_i    (mant_q),
    .sticky_i  (sticky_q),
    .mant_o    (rnd_mant_s),
    .inexact_o (rnd_inexact_s)
  );

  // Next-state, datapath update and output register values.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    sticky_d    = sticky_q;
    flush_d     = flush_q;
    result_d    = result_q;
    done_d      = 1'b0;
    busy_d      = busy_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    inexact_d   = inexact_q;
`ifdef FP_NORM_SUBNORMAL_EN
    dcnt_d      = dcnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d      = sign_in;
          exp_d       = {{(FP_EXP_INT_W-FP_EXP_IN_W){exp_in[FP_EXP_IN_W-1]}}, exp_in};
          mant_d      = mant_in;
          sticky_d    = sticky_in;
          flush_d     = 1'b0;
          busy_d      = 1'b1;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          inexact_d   = 1'b0;
`ifdef FP_NORM_SUBNORMAL_EN
          dcnt_d      = 5'd0;
`endif
          state_d     = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        if (mant_q == {FP_MANT_W{1'b0}}) begin
          state_d = PACK;
        end else if (mant_q[FP_MANT_W-1]) begin
          mant_d   = {1'b0, mant_q[FP_MANT_W-1:1]};
          sticky_d = sticky_q | mant_q[0];
          exp_d    = exp_q + 12'sd1;
`ifdef FP_NORM_SUBNORMAL_EN
        end else if ((exp_q < 12'sd1) && (dcnt_q < 5'd26)) begin
          // Denormalise toward the minimum exponent, folding lost bits into sticky.
          mant_d   = {1'b0, mant_q[FP_MANT_W-1:1]};
          sticky_d = sticky_q | mant_q[0];
          exp_d    = exp_q + 12'sd1;
          dcnt_d   = dcnt_q + 5'd1;
`endif
        end else if (!mant_q[FP_MANT_W-2] && (exp_q > 12'sd1)) begin
          mant_d = {mant_q[FP_MANT_W-2:0], 1'b0};
          exp_d  = exp_q - 12'sd1;
        end else begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        inexact_d = rnd_inexact_s;
        if (rnd_mant_s[FP_MANT_W-3]) begin
          mant_d = {1'b0, rnd_mant_s, 1'b0};
          exp_d  = exp_q + 12'sd1;
        end else begin
          mant_d = {rnd_mant_s, 2'b00};
        end
`ifdef FP_NORM_SUBNORMAL_EN
        flush_d = 1'b0;
`else
        flush_d = (exp_q < 12'sd1);
`endif
        state_d = PACK;
      end

      PACK: begin
        if (flush_q) begin
          result_d    = fp_pack(sign_q, FP_EXP_ZERO, FP_FRAC_ZERO);
          underflow_d = 1'b1;
          inexact_d   = 1'b1;
        end else if ((exp_q >= 12'sd255) && (mant_q != {FP_MANT_W{1'b0}})) begin
          result_d   = fp_pack(sign_q, FP_EXP_MAX, FP_FRAC_ZERO);
          overflow_d = 1'b1;
          inexact_d  = 1'b1;
        end else if (!mant_q[FP_MANT_W-2]) begin
          // Hidden bit clear: subnormal encoding (or signed zero).
          result_d = fp_pack(sign_q, FP_EXP_ZERO, mant_q[FP_MANT_W-3:2]);
`ifdef FP_NORM_SUBNORMAL_EN
          underflow_d = inexact_q;
`else
          underflow_d = 1'b0;
`endif
        end else begin
          result_d = fp_pack(sign_q, exp_q[FP_EXP_W-1:0], mant_q[FP_MANT_W-3:2]);
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= 12'sd0;
      mant_q      <= {FP_MANT_W{1'b0}};
      sticky_q    <= 1'b0;
      flush_q     <= 1'b0;
      result_q    <= 32'd0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      inexact_q   <= 1'b0;
`ifdef FP_NORM_SUBNORMAL_EN
      dcnt_q      <= 5'd0;
`endif
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      sticky_q    <= sticky_d;
      flush_q     <= flush_d;
      result_q    <= result_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      inexact_q   <= inexact_d;
`ifdef FP_NORM_SUBNORMAL_EN
      dcnt_q      <= dcnt_d;
`endif
    end
  end

  assign result    = result_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round: directed corner cases plus randomized
// operands compared against a leading-one based reference model.
module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sign_in = 1'b0;
  logic [9:0]  exp_in = 10'd0;
  logic [26:0] mant_in = 27'd0;
  logic        sticky_in = 1'b0;
  logic [31:0] result;
  logic        done, busy, overflow, underflow, inexact;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

`ifdef FP_NORM_SUBNORMAL_EN
  localparam bit SUBN = 1'b1;
`else
  localparam bit SUBN = 1'b0;
`endif

  fp_norm_round dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .sticky_in (sticky_in),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Reference: value-level normalisation via leading-one position, then RNE and packing.
  task automatic ref_model(input logic s, input int e_in, input logic [26:0] m_in, input logic st_in,
                           output logic [31:0] res, output logic ov, output logic uf,
                           output logic ix, output int lat);
    logic [26:0] mm;
    logic [24:0] q;
    logic        st, g, r, inc;
    int          e, sh, p, k;
    mm = m_in; e = e_in; st = st_in; sh = 0;
    ov = 1'b0; uf = 1'b0; ix = 1'b0;
    res = {s, 31'd0};
    lat = 2;
    if (mm == 27'd0) return;
    if (mm[26]) begin
      st = st | mm[0]; mm = mm >> 1; e = e + 1; sh = sh + 1;
    end
    p = 0;
    for (int i = 0; i < 27; i++) if (mm[i]) p = i;
    if (SUBN && e < 1) begin
      k = (1 - e > 26) ? 26 : 1 - e;
      if (k > p) begin
        lat = 2 + sh + p + 1;
        return;
      end
      st = st | ((mm & ((27'd1 << k) - 27'd1)) != 27'd0);
      mm = mm >> k; e = e + k; sh = sh + k;
    end else if (e > 1) begin
      k = (25 - p < e - 1) ? 25 - p : e - 1;
      mm = mm << k; e = e - k; sh = sh + k;
    end
    lat = 3 + sh;
    if (!SUBN && e < 1) begin
      uf = 1'b1; ix = 1'b1;
      return;
    end
    g = mm[1]; r = mm[0] | st;
    inc = g & (r | mm[2]);
    ix = g | r;
    q = mm[26:2] + {24'd0, inc};
    if (q[24]) begin q = q >> 1; e = e + 1; end
    if (e >= 255) begin
      res = {s, 8'hFF, 23'd0}; ov = 1'b1; ix = 1'b1;
    end else if (!q[23]) begin
      res = {s, 8'h00, q[22:0]};
    end else begin
      res = {s, e[7:0], q[22:0]};
    end
    if (SUBN && res[30:23] == 8'h00 && ix) uf = 1'b1;
  endtask

  task automatic run_op(input string tag, input logic s, input logic [9:0] e, input logic [26:0] m,
                        input logic st, output logic [31:0] got_res, output int got_lat);
    logic [31:0] w_res;
    logic        w_ov, w_uf, w_ix;
    int          w_lat;
    ref_model(s, int'($signed(e)), m, st, w_res, w_ov, w_uf, w_ix, w_lat);
    @(negedge clk);
    sign_in = s; exp_in = e; mant_in = m; sticky_in = st; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    got_lat = 0;
    while (done !== 1'b1 && got_lat < 64) begin
      @(posedge clk); #1;
      got_lat++;
    end
    got_res = result;
    check({tag, "_lat"}, 32'(got_lat), 32'(w_lat));
    check({tag, "_res"}, result, w_res);
    check({tag, "_flags"}, {29'd0, overflow, underflow, inexact}, {29'd0, w_ov, w_uf, w_ix});
    @(posedge clk); #1;
    check({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] res;
    int          lat, c0, sel, w;
    logic [26:0] m;
    logic [9:0]  e;

    #12;
    check("rst_res", result, 32'd0);
    check("rst_ctrl", {27'd0, done, busy, overflow, underflow, inexact}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("one", 1'b0, 10'd127, 27'h2000000, 1'b0, res, lat);
    check("one_spec_res", res, 32'h3F800000);
    check("one_spec_lat", 32'(lat), 32'd3);
    check("one_spec_flags", {29'd0, overflow, underflow, inexact}, 32'd0);

    run_op("carry", 1'b0, 10'd127, 27'h4000000, 1'b0, res, lat);
    check("carry_spec_res", res, 32'h40000000);
    check("carry_spec_lat", 32'(lat), 32'd4);

    run_op("rne_tie", 1'b0, 10'd127, 27'h2000002, 1'b0, res, lat);
    check("rne_tie_spec_res", res, 32'h3F800000);
    check("rne_tie_spec_ix", {31'd0, inexact}, 32'd1);

    run_op("rne_up", 1'b0, 10'd127, 27'h2000006, 1'b0, res, lat);
    check("rne_up_spec_res", res, 32'h3F800002);

    run_op("zero", 1'b1, 10'd127, 27'h0000000, 1'b0, res, lat);
    check("zero_spec_res", res, 32'h80000000);

    run_op("left", 1'b0, 10'd150, 27'h0000004, 1'b0, res, lat);
    check("left_spec_res", res, 32'h3F800000);
    check("left_spec_lat", 32'(lat), 32'd26);

    run_op("ovf", 1'b0, 10'd254, 27'h4000000, 1'b0, res, lat);
    check("ovf_spec_res", res, 32'h7F800000);
    check("ovf_spec_flag", {31'd0, overflow}, 32'd1);

    // Reset in the middle of a long left-normalisation.
    @(negedge clk);
    sign_in = 1'b0; exp_in = 10'd150; mant_in = 27'h0000004; sticky_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    c0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("rst_mid_res", result, 32'd0);
    check("rst_mid_ctrl", {27'd0, done, busy, overflow, underflow, inexact}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("rst_mid_no_done", 32'(done_cnt - c0), 32'd0);

    // Start pulses while busy are ignored.
    c0 = done_cnt;
    @(negedge clk);
    sign_in = 1'b0; exp_in = 10'd150; mant_in = 27'h0000004; sticky_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sign_in = 1'b1; exp_in = 10'd200; mant_in = 27'h4000000; start = 1'b1;
    end
    @(negedge clk); start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("ign_done_cnt", 32'(done_cnt - c0), 32'd1);
    check("ign_res", result, 32'h3F800000);

    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       e = 10'($urandom_range(1, 254));
        1:       e = 10'($urandom_range(245, 300));
        2:       e = 10'(int'($urandom_range(0, 40)) - 30);
        default: e = 10'($urandom);
      endcase
      w = int'($urandom_range(0, 27));
      m = 27'($urandom) & ((27'd1 << w) - 27'd1);
      run_op($sformatf("rnd%0d", i), 1'($urandom), e, m, 1'($urandom), res, lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_norm_round.md
FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 SHALL have port clk, input, 1, system clock (100 MHz), all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1, request; sampled only in IDLE.
REQ-004 SHALL have port sign_in, input, 1, sign of the unrounded sum.
REQ-005 SHALL have port exp_in, input, 10, signed biased exponent (bias 127).
REQ-006 SHALL have port mant_in, input, 27: bit26 carry, bit25 hidden, bits24:2 fraction, bit1 guard, bit0 round.
REQ-007 SHALL have port sticky_in, input, 1, OR of all discarded lower bits.
REQ-008 SHALL have port result, output, 32, IEEE 754 single result.
REQ-009 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port busy, output, 1, high from accept until done.
REQ-011 SHALL have ports overflow, underflow, inexact, output, 1 each, status valid with done and held until next accept.

Function
REQ-012 SHALL use FSM states IDLE, SHIFT, ROUND, PACK.
- IDLE->SHIFT on start; capture all inputs; busy=1.
- start outside IDLE ignored.
REQ-013 SHALL perform one SHIFT action per cycle, in priority order:
- m==0 -> PACK (signed zero).
- m[26]=1 -> right 1, sticky|=m[0], exp+1.
- m[25]=0 and exp>1 -> left 1, exp-1.
- Otherwise -> ROUND.
REQ-014 SHALL round to nearest even in ROUND:
- increment m[26:2] when m[1]&(m[0]|sticky|m[2]).
- inexact = m[1]|m[0]|sticky.
- if increment sets m[26]: right 1, exp+1.
REQ-015 SHALL in PACK:
- exp>=255 -> {sign,8'hFF,0}, overflow=1, inexact=1.
- m[25]=0 -> exponent field 0.
- Otherwise {sign,exp[7:0],m[24:2]}.
- Register result; done=1 for one cycle; return IDLE.
REQ-016 SHALL have latency start-sample to done = 3 + number of shift cycles; maximum 3+26.
REQ-017 SHALL hold result after done until the next PACK.

Reset
REQ-018 SHALL on rst_n low, at any time including mid-operation:
- state=IDLE; result=0; done=busy=overflow=underflow=inexact=0.
- Any in-flight operation discarded, no done.

Configuration
REQ-019 SHALL, with FP_NORM_SUBNORMAL_EN defined:
- SHIFT right-shifts (sticky accumulated, exp+1) while exp<1, up to 26 shifts.
- underflow=1 when final exponent field 0 and inexact.
REQ-020 SHALL, without FP_NORM_SUBNORMAL_EN:
- Any operand reaching ROUND with exp<1 packs signed zero.
- underflow=1 and inexact=1 in that case.

Structure
REQ-021 SHALL take from shared package fp_pkg:
- FP_BIAS=127, exponent/mantissa width constants.
- State enum typedef.
- Same package as the upstream FMA datapath.
REQ-022 SHALL place rounding increment/inexact logic in combinational sub-module fp_round_rne, instantiated once.

Verification
REQ-023 SHALL cover 1.0: sign0, exp127, mant 0x2000000, sticky0 -> result 0x3F800000, done 3 cycles after start, flags 0.
REQ-024 SHALL cover carry normalisation: exp127, mant 0x4000000 -> 0x40000000, latency 4.
REQ-025 SHALL cover round-to-even:
- mant 0x2000002 -> 0x3F800000, inexact=1.
- mant 0x2000006 -> 0x3F800002.
REQ-026 SHALL cover overflow: exp254, mant 0x4000000 -> 0x7F800000, overflow=1.
REQ-027 SHALL cover left normalise and zero:
- exp150, mant 0x0000004 -> 0x3F800000 after 23 shifts, latency 26.
- sign1, mant 0 -> 0x80000000.
REQ-028 SHALL cover reset and ignored start:
- rst_n low during SHIFT -> no done, outputs 0.
- start pulsed while busy -> ignored, exactly one done.
